// File: rtl/seq_mult16_ctrl.sv
// ---------------------------------------------------------------------------
// seq_mult16_ctrl
// Iterative 16x16 unsigned shift-and-add multiplier controller (EX stage).
// Each RUN cycle it feeds the latched multiplicand and the current multiplier
// LSB to the external bit-mask AND stage and adds the returned partial product
// into the upper half of a 32-bit accumulator, then shifts right by one.
// After 16 iterations the product is published with a one-cycle done pulse.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset (priority over start/abort)
//   start     request, sampled only in IDLE or DONE
//   abort     cancels an in-flight multiply (RUN only)
//   a, b      multiplicand / multiplier, captured on accepted start
//   mask_x    to mask stage vector input (latched multiplicand)
//   mask_y    to mask stage enable input (current multiplier LSB)
//   mask_out  from mask stage, combinational partial product
//   busy      high while in RUN
//   done      one-cycle pulse when product is updated
//   product   last completed 32-bit result, held until next completion
// ---------------------------------------------------------------------------
module seq_mult16_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] mask_x,
    output logic        mask_y,
    input  logic [15:0] mask_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_r;
    state_t             next_state_s;
    logic [15:0]        mcand_r;
    logic [31:0]        acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [31:0]        product_r;
    logic               busy_r;
    logic               done_r;

    logic               load_s;
    logic               iter_s;
    logic               finish_s;
    logic               busy_nx_s;
    logic               done_nx_s;
    logic [16:0]        sum_s;
    logic [31:0]        acc_nx_s;

    // Add the partial product to the running sum; the carry becomes acc[31]
    // after the right shift, so the 32-bit product is exact.
    assign sum_s    = {1'b0, acc_r[31:16]} + {1'b0, mask_out};
    assign acc_nx_s = {sum_s, acc_r[15:1]};

    assign mask_x  = mcand_r;
    assign mask_y  = acc_r[0];
    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

    // State register plus registered busy/done flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= busy_nx_s;
            done_r  <= done_nx_s;
        end
    end

    // Next-state decode; abort only matters in RUN, start only outside RUN.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    next_state_s = IDLE;
                end else if (cnt_r == LAST_CNT) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Datapath strobes and next values of the registered status outputs.
    always_comb begin
        load_s    = 1'b0;
        iter_s    = 1'b0;
        finish_s  = 1'b0;
        busy_nx_s = (next_state_s == RUN);
        done_nx_s = (next_state_s == DONE);
        case (state_r)
            IDLE, DONE: begin
                load_s = start;
            end
            RUN: begin
                iter_s   = ~abort;
                finish_s = ~abort & (cnt_r == LAST_CNT);
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Operand capture, iteration and result publication.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_r   <= 16'h0000;
            acc_r     <= 32'h0000_0000;
            cnt_r     <= '0;
            product_r <= 32'h0000_0000;
        end else begin
            if (load_s) begin
                mcand_r <= a;
                acc_r   <= {16'h0000, b};
                cnt_r   <= '0;
            end else if (iter_s) begin
                acc_r <= acc_nx_s;
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                acc_r <= acc_r;
                cnt_r <= cnt_r;
            end
            // Only the final iteration updates product, so it never shows
            // a partial sum.
            if (finish_s) begin
                product_r <= acc_nx_s;
            end else begin
                product_r <= product_r;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult16_ctrl.sv
module tb_seq_mult16_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] mask_x;
    logic        mask_y;
    logic [15:0] mask_out;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks = 0;
    int errors = 0;

    seq_mult16_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .a        (a),
        .b        (b),
        .mask_x   (mask_x),
        .mask_y   (mask_y),
        .mask_out (mask_out),
        .busy     (busy),
        .done     (done),
        .product  (product)
    );

    // Model of the existing bit-mask AND stage.
    assign mask_out = mask_x & {16{mask_y}};

    always #5 clk = ~clk;

    // Present a start pulse at a negedge; returns at the negedge after the
    // accepting edge.
    task automatic issue_start(input logic [15:0] av, input logic [15:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observe until done (bounded); records edges elapsed, busy cycles and
    // the mask_y bit seen in each iteration.
    task automatic wait_done(output int cyc, output int busy_cyc, output logic [15:0] seq);
        cyc      = 0;
        busy_cyc = 0;
        seq      = 16'h0000;
        while (done !== 1'b1 && cyc < 40) begin
            if (cyc < 16) seq[cyc] = mask_y;
            if (busy === 1'b1) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a     = 16'hAAAA;
        b     = 16'h5555;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (product !== 32'h0) begin errors++; $display("FAIL reset_product got %h want 0", product); end
        checks++; if (mask_x !== 16'h0) begin errors++; $display("FAIL reset_mask_x got %h want 0", mask_x); end
        checks++; if (mask_y !== 1'b0) begin errors++; $display("FAIL reset_mask_y got %b want 0", mask_y); end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc; int bc; logic [15:0] seq;
        issue_start(16'd3, 16'd5);
        checks++; if (mask_x !== 16'd3) begin errors++; $display("FAIL basic_mask_x got %h want 0003", mask_x); end
        wait_done(cyc, bc, seq);
        checks++; if (cyc !== 16) begin errors++; $display("FAIL basic_latency got %0d want 16", cyc); end
        checks++; if (bc !== 16) begin errors++; $display("FAIL basic_busy_cycles got %0d want 16", bc); end
        checks++; if (seq !== 16'h0005) begin errors++; $display("FAIL basic_mask_y_seq got %h want 0005", seq); end
        checks++; if (product !== 32'h0000_000F) begin errors++; $display("FAIL basic_product got %h want 0000000f", product); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done got %b want 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done); end
        checks++; if (product !== 32'h0000_000F) begin errors++; $display("FAIL basic_product_hold got %h want 0000000f", product); end
    endtask

    task automatic test_max();
        int cyc; int bc; logic [15:0] seq;
        issue_start(16'hFFFF, 16'hFFFF);
        wait_done(cyc, bc, seq);
        checks++; if (cyc !== 16) begin errors++; $display("FAIL max_latency got %0d want 16", cyc); end
        checks++; if (seq !== 16'hFFFF) begin errors++; $display("FAIL max_mask_y_seq got %h want ffff", seq); end
        checks++; if (product !== 32'hFFFE_0001) begin errors++; $display("FAIL max_product got %h want fffe0001", product); end
        @(negedge clk);
    endtask

    task automatic test_zero();
        int cyc; int bc; logic [15:0] seq;
        issue_start(16'h1234, 16'h0000);
        checks++; if (mask_x !== 16'h1234) begin errors++; $display("FAIL zero_mask_x got %h want 1234", mask_x); end
        wait_done(cyc, bc, seq);
        checks++; if (cyc !== 16) begin errors++; $display("FAIL zero_latency got %0d want 16", cyc); end
        checks++; if (seq !== 16'h0000) begin errors++; $display("FAIL zero_mask_y_seq got %h want 0000", seq); end
        checks++; if (product !== 32'h0) begin errors++; $display("FAIL zero_product got %h want 0", product); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc; int bc; logic [15:0] seq;
        issue_start(16'd7, 16'd9);
        // Start held during RUN with different operands must be ignored.
        a     = 16'd1;
        b     = 16'd1;
        start = 1'b1;
        wait_done(cyc, bc, seq);
        checks++; if (cyc !== 16) begin errors++; $display("FAIL b2b_first_latency got %0d want 16", cyc); end
        checks++; if (product !== 32'd63) begin errors++; $display("FAIL b2b_first_product got %h want 0000003f", product); end
        // Start issued in the DONE cycle.
        issue_start(16'h00FF, 16'h0100);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got %b want 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_restart_done got %b want 0", done); end
        checks++; if (mask_x !== 16'h00FF) begin errors++; $display("FAIL b2b_restart_mask_x got %h want 00ff", mask_x); end
        wait_done(cyc, bc, seq);
        checks++; if (cyc + 1 !== 17) begin errors++; $display("FAIL b2b_done_spacing got %0d want 17", cyc + 1); end
        checks++; if (product !== 32'h0000_FF00) begin errors++; $display("FAIL b2b_second_product got %h want 0000ff00", product); end
        @(negedge clk);
    endtask

    task automatic test_abort_reset();
        int cyc; int bc; logic [15:0] seq; int done_seen;
        issue_start(16'd2, 16'd3);
        wait_done(cyc, bc, seq);
        checks++; if (product !== 32'd6) begin errors++; $display("FAIL abort_pre_product got %h want 00000006", product); end
        @(negedge clk);
        issue_start(16'd100, 16'd100);
        repeat (7) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", done_seen); end
        checks++; if (product !== 32'd6) begin errors++; $display("FAIL abort_product_hold got %h want 00000006", product); end
        // Abort together with start in IDLE: start wins.
        abort = 1'b1;
        issue_start(16'd10, 16'd10);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_idle_start got busy %b want 1", busy); end
        abort = 1'b0;
        wait_done(cyc, bc, seq);
        checks++; if (product !== 32'd100) begin errors++; $display("FAIL abort_idle_product got %h want 00000064", product); end
        @(negedge clk);
        // Reset mid-RUN.
        issue_start(16'd9, 16'd9);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
        checks++; if (product !== 32'h0) begin errors++; $display("FAIL midrst_product got %h want 0", product); end
        checks++; if (mask_x !== 16'h0) begin errors++; $display("FAIL midrst_mask_x got %h want 0", mask_x); end
        checks++; if (mask_y !== 1'b0) begin errors++; $display("FAIL midrst_mask_y got %b want 0", mask_y); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        @(negedge clk);
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_back_to_back();
        test_abort_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
